// File: rtl/disp_pkg.sv
// disp_pkg: shared types and default timing constants for the display blocks
package disp_pkg;
    typedef enum logic {SCORE, MSG} disp_state_t;
    typedef logic [15:0] digit_word_t;
    typedef struct packed {
        digit_word_t data;
        logic [3:0]  dp;
        logic        blink;
    } disp_msg_t;
    localparam int TICK_DIV_DEF    = 5_000_000;
    localparam int HOLD_TICKS_DEF  = 40;
    localparam int BLINK_TICKS_DEF = 5;
endpackage

// File: rtl/disp_msg_sched_if.sv
// disp_msg_sched_if: score/message inputs and display-driver outputs of the scheduler
interface disp_msg_sched_if;
    import disp_pkg::*;
    digit_word_t score_val;
    logic [3:0]  score_dp;
    logic        msg_req;
    digit_word_t msg_data;
    logic [3:0]  msg_dp;
    logic        msg_blink;
    logic        msg_clear;
    logic        msg_ack;
    logic        msg_busy;
    logic [3:0]  hex3;
    logic [3:0]  hex2;
    logic [3:0]  hex1;
    logic [3:0]  hex0;
    logic [3:0]  dp_out;
    modport master (
        output score_val, score_dp, msg_req, msg_data, msg_dp, msg_blink, msg_clear,
        input  msg_ack, msg_busy, hex3, hex2, hex1, hex0, dp_out
    );
    modport slave (
        input  score_val, score_dp, msg_req, msg_data, msg_dp, msg_blink, msg_clear,
        output msg_ack, msg_busy, hex3, hex2, hex1, hex0, dp_out
    );
endinterface

// File: rtl/disp_tick_gen.sv
// disp_tick_gen: one-cycle tick every TICK_DIV clocks, realigned by a synchronous restart
module disp_tick_gen
    import disp_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_restart,
    output logic o_tick
);
    localparam int CW = $clog2(TICK_DIV);
    logic [CW-1:0] r_cnt;
    assign o_tick = (r_cnt == CW'(TICK_DIV - 1));
    always_ff @(posedge clk) begin
        if (reset || i_restart || o_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/disp_msg_sched.sv
// disp_msg_sched: arbitrates display ownership between live score and timed messages
module disp_msg_sched
    import disp_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_DEF,
    parameter int HOLD_TICKS  = HOLD_TICKS_DEF,
    parameter int BLINK_TICKS = BLINK_TICKS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    disp_msg_sched_if.slave  bus
);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);
    disp_state_t r_state, w_state_nxt;
    disp_msg_t   r_act, r_pend, w_in;
    logic        r_pend_valid;
    logic [HW-1:0] r_hold;
    logic [BW-1:0] r_bcnt;
    logic        r_phase;
    digit_word_t r_hex;
    logic [3:0]  r_dp;
    logic w_tick, w_hold_done, w_restart, w_show_score;
    logic w_ack, w_load_new, w_promote, w_load_pend, w_drop_pend;
    assign w_in        = {bus.msg_data, bus.msg_dp, bus.msg_blink};
    assign w_hold_done = (r_state == MSG) && w_tick && (r_hold == HW'(HOLD_TICKS - 1));
    assign w_restart   = w_load_new | w_promote;
    disp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );
    // clear beats expiry and request; an expiring message hands over to pending first
    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_load_new  = 1'b0;
        w_promote   = 1'b0;
        w_load_pend = 1'b0;
        w_drop_pend = 1'b0;
        if (bus.msg_clear) begin
            w_state_nxt = SCORE;
            w_drop_pend = 1'b1;
        end else if (r_state == SCORE) begin
            if (bus.msg_req) begin
                w_ack       = 1'b1;
                w_load_new  = 1'b1;
                w_state_nxt = MSG;
            end
        end else if (w_hold_done) begin
            if (r_pend_valid) begin
                w_promote = 1'b1;
            end else if (bus.msg_req) begin
                w_ack      = 1'b1;
                w_load_new = 1'b1;
            end else begin
                w_state_nxt = SCORE;
            end
        end else if (bus.msg_req && !r_pend_valid) begin
            w_ack       = 1'b1;
            w_load_pend = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= SCORE;
            r_act        <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_hold       <= '0;
            r_bcnt       <= '0;
            r_phase      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_act        <= w_load_new ? w_in : w_promote ? r_pend : r_act;
            r_pend       <= w_load_pend ? w_in : r_pend;
            r_pend_valid <= (w_drop_pend || w_promote) ? 1'b0 : w_load_pend ? 1'b1 : r_pend_valid;
            if (w_restart) begin
                r_hold  <= '0;
                r_bcnt  <= '0;
                r_phase <= 1'b0;
            end else if (w_tick && r_state == MSG) begin
                r_hold <= r_hold + 1'b1;
                if (r_act.blink) begin
                    r_bcnt  <= (r_bcnt == BW'(BLINK_TICKS - 1)) ? '0 : r_bcnt + 1'b1;
                    r_phase <= (r_bcnt == BW'(BLINK_TICKS - 1)) ? ~r_phase : r_phase;
                end
            end
        end
    end
    assign w_show_score = (r_state == SCORE) || (r_act.blink && r_phase);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hex <= '0;
            r_dp  <= 4'b1111;
        end else begin
            r_hex <= w_show_score ? bus.score_val : r_act.data;
            r_dp  <= w_show_score ? bus.score_dp : r_act.dp;
        end
    end
    assign bus.msg_ack  = w_ack & ~reset;
    assign bus.msg_busy = (r_state == MSG) | r_pend_valid;
    assign {bus.hex3, bus.hex2, bus.hex1, bus.hex0} = r_hex;
    assign bus.dp_out   = r_dp;
endmodule
